register_file: RTL and testbench

- Architectural 32x32 integer register file for the 5-stage RISC-V pipeline.
- Consumes the writeback-stage result (destination index, write enable and 32-bit result) at its single write port.
- Serves two combinational read ports to the decode stage.
- Carries a committed-write counter and a debug read port for the bench and bring-up.

---
 rtl/register_file.sv | 82 ++++++++
 tb/tb_register_file.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 32 x XLEN architectural integer register file.
// One write port fed by writeback, two combinational read ports for decode,
// a debug read port that always shows stored state, and a committed-write counter.
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle write-to-read
// forwarding on RD1/RD2; DbgRD never forwards.
module register_file #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     RegWriteW,
    input  logic [$clog2(NREG)-1:0]  RdW,
    input  logic [XLEN-1:0]          ResultW,
    input  logic [$clog2(NREG)-1:0]  A1,
    input  logic [$clog2(NREG)-1:0]  A2,
    output logic [XLEN-1:0]          RD1,
    output logic [XLEN-1:0]          RD2,
    input  logic [$clog2(NREG)-1:0]  DbgA,
    output logic [XLEN-1:0]          DbgRD,
    output logic [CNT_W-1:0]         WriteCount
);

    localparam int unsigned AW = $clog2(NREG);

    logic [XLEN-1:0]  regs [NREG];
    logic [CNT_W-1:0] write_count;
    logic             write_fire;

    // A write commits only when enabled and not aimed at the hardwired x0
    always_comb begin
        write_fire = RegWriteW && (RdW != '0);
    end

    // Register array and counter update; reset wins over a same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            write_count <= '0;
        end else if (write_fire) begin
            regs[RdW]   <= ResultW;
            write_count <= write_count + CNT_W'(1);
        end
    end

    // Decode read ports: stored value, optionally forwarded, x0 forced to zero last
    always_comb begin
        RD1 = regs[A1];
        RD2 = regs[A2];
`ifdef REGFILE_BYPASS_EN
        if (write_fire && (A1 == RdW)) begin
            RD1 = ResultW;
        end
        if (write_fire && (A2 == RdW)) begin
            RD2 = ResultW;
        end
`endif
        if (A1 == AW'(0)) begin
            RD1 = '0;
        end
        if (A2 == AW'(0)) begin
            RD2 = '0;
        end
    end

    // Debug port shows committed state only, never the in-flight write
    always_comb begin
        DbgRD = regs[DbgA];
        if (DbgA == AW'(0)) begin
            DbgRD = '0;
        end
    end

    // Counter is exposed directly; it wraps naturally at 2^CNT_W
    always_comb begin
        WriteCount = write_count;
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed bench for register_file with a behavioural model
// checked every cycle, plus literal expectations at the test-plan points.
// A second instance with an 8-bit counter exercises counter wrap-around.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [4:0]  DbgA;
    logic [31:0] RD1, RD2, DbgRD, WriteCount;
    logic [31:0] RD1_s, RD2_s, DbgRD_s;
    logic [7:0]  WriteCount_s;

    int checks = 0;
    int errors = 0;

    register_file #(.XLEN(32), .NREG(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .DbgA(DbgA), .DbgRD(DbgRD),
        .WriteCount(WriteCount)
    );

    register_file #(.XLEN(32), .NREG(32), .CNT_W(8)) dut_small (
        .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .A1(A1), .A2(A2), .RD1(RD1_s), .RD2(RD2_s), .DbgA(DbgA), .DbgRD(DbgRD_s),
        .WriteCount(WriteCount_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Behavioural model: architectural contents and number of committed writes
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
            m_cnt   <= 32'h0;
            m_valid <= 1'b1;
        end else if (RegWriteW && RdW != 5'd0) begin
            m_regs[RdW] <= ResultW;
            m_cnt       <= m_cnt + 32'd1;
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit fwd);
        if (idx == 5'd0) return 32'h0;
        if (fwd && BYPASS && RegWriteW && RdW == idx) return ResultW;
        return m_regs[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("rd1",       RD1,        exp_read(A1, 1'b1));
            check("rd2",       RD2,        exp_read(A2, 1'b1));
            check("dbg",       DbgRD,      exp_read(DbgA, 1'b0));
            check("count",     WriteCount, m_cnt);
            check("rd1_s",     RD1_s,      exp_read(A1, 1'b1));
            check("rd2_s",     RD2_s,      exp_read(A2, 1'b1));
            check("dbg_s",     DbgRD_s,    exp_read(DbgA, 1'b0));
            check("count_s",   {24'h0, WriteCount_s}, {24'h0, m_cnt[7:0]});
        end
    end

    // Inputs change 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Literal checks land just after the falling edge, clear of the model compare
    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'h0;
        A1 = 5'd0; A2 = 5'd0; DbgA = 5'd0;
        tick();
        rst = 1'b0;
        sample();
        check("lit_reset_count", WriteCount, 32'd0);
        check("lit_reset_rd1",   RD1,        32'd0);

        // Reset clear, with a write presented during reset being dropped
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEADBEEF; DbgA = 5'd5;
        tick();
        RegWriteW = 1'b0;
        sample();
        check("lit_x5_written", DbgRD, 32'hDEADBEEF);
        check("lit_count1",     WriteCount, 32'd1);
        rst = 1'b1; RegWriteW = 1'b1; RdW = 5'd6; ResultW = 32'h0BAD0BAD;
        tick();
        rst = 1'b0; RegWriteW = 1'b0; A1 = 5'd5; DbgA = 5'd6;
        sample();
        check("lit_clr_rd1_x5", RD1,        32'd0);
        check("lit_clr_dbg_x6", DbgRD,      32'd0);
        check("lit_clr_count",  WriteCount, 32'd0);

        // Basic write/read on consecutive cycles
        RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h12345678;
        tick();
        RdW = 5'd31; ResultW = 32'hFFFFFFFF;
        tick();
        RegWriteW = 1'b0; A1 = 5'd1; A2 = 5'd31;
        sample();
        check("lit_rd1_x1",  RD1,        32'h12345678);
        check("lit_rd2_x31", RD2,        32'hFFFFFFFF);
        check("lit_count2",  WriteCount, 32'd2);

        // x0 protection, same cycle and after the edge
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hAAAA5555; A1 = 5'd0; A2 = 5'd0;
        sample();
        check("lit_x0_same", RD1, 32'd0);
        tick();
        RegWriteW = 1'b0;
        sample();
        check("lit_x0_after",  RD1,        32'd0);
        check("lit_x0_count",  WriteCount, 32'd2);

        // Same-cycle hazard on x7
        RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h11;
        tick();
        ResultW = 32'h22; A1 = 5'd7; A2 = 5'd7; DbgA = 5'd7;
        sample();
        check("lit_haz_rd1", RD1,   BYPASS ? 32'h22 : 32'h11);
        check("lit_haz_rd2", RD2,   BYPASS ? 32'h22 : 32'h11);
        check("lit_haz_dbg", DbgRD, 32'h11);
        tick();
        RegWriteW = 1'b0;
        sample();
        check("lit_haz_next_rd1", RD1,        32'h22);
        check("lit_haz_next_rd2", RD2,        32'h22);
        check("lit_haz_next_dbg", DbgRD,      32'h22);
        check("lit_haz_count",    WriteCount, 32'd4);

        // Write disabled leaves x3 alone
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h33;
        tick();
        RegWriteW = 1'b0; ResultW = 32'h99; A1 = 5'd3;
        tick();
        sample();
        check("lit_wdis_x3",    RD1,        32'h33);
        check("lit_wdis_count", WriteCount, 32'd5);

        // Write to one index while reading others
        RegWriteW = 1'b1; RdW = 5'd8; ResultW = 32'h88; A1 = 5'd1; A2 = 5'd31;
        sample();
        check("lit_indep_rd1", RD1, 32'h12345678);
        check("lit_indep_rd2", RD2, 32'hFFFFFFFF);
        tick();

        // Counter wrap: 8-bit instance rolls over after 256 writes
        rst = 1'b1; RegWriteW = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 255; i++) begin
            RegWriteW = 1'b1;
            RdW       = 5'((i % 31) + 1);
            ResultW   = 32'(i) + 32'h1000;
            A1        = 5'(i % 32);
            A2        = 5'((i * 7) % 32);
            tick();
        end
        RegWriteW = 1'b0;
        sample();
        check("lit_pre_wrap_s", {24'h0, WriteCount_s}, 32'd255);
        RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'hCAFEF00D;
        tick();
        RegWriteW = 1'b0; DbgA = 5'd2;
        sample();
        check("lit_wrap_s",     {24'h0, WriteCount_s}, 32'd0);
        check("lit_wrap_x2_s",  DbgRD_s,    32'hCAFEF00D);
        check("lit_wrap_main",  WriteCount, 32'd256);

        // Mid-operation reset clears every index
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            DbgA = 5'(i); A1 = 5'(31 - i); A2 = 5'(i);
            sample();
            check("lit_rst_all", DbgRD, 32'd0);
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
